// File: rtl/hex_display_ctrl.sv
// Display scheduler: arbitrates note/velocity values onto one shared 7-bit
// double-dabble converter and holds velocity on screen before reverting to the note.
module hex_display_ctrl #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       note_valid,
   input  logic [6:0] note_val,
   input  logic       vel_valid,
   input  logic [6:0] vel_val,
   output logic [3:0] bcd_hun,
   output logic [3:0] bcd_ten,
   output logic [3:0] bcd_one,
   output logic [2:0] blank,
   output logic       src,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   state_t            state_q, state_d;
   logic              note_pend_q, note_pend_d;
   logic              vel_pend_q, vel_pend_d;
   logic [6:0]        note_last_q, note_last_d;
   logic [6:0]        vel_hold_q, vel_hold_d;
   logic              cur_src_q, cur_src_d;
   logic [18:0]       sr_q, sr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]        hun_q, hun_d, ten_q, ten_d, one_q, one_d;
   logic [2:0]        blank_q, blank_d;
   logic              src_q, src_d;
   logic [3:0]        ten_adj, one_adj;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d     = state_q;
      note_pend_d = note_pend_q;
      vel_pend_d  = vel_pend_q;
      note_last_d = note_last_q;
      vel_hold_d  = vel_hold_q;
      cur_src_d   = cur_src_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      hun_d       = hun_q;
      ten_d       = ten_q;
      one_d       = one_q;
      blank_d     = blank_q;
      src_d       = src_q;
      ten_adj     = sr_q[14:11];
      one_adj     = sr_q[10:7];
      hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - HOLD_ONE : hold_cnt_q;

      case (state_q)
         IDLE: begin
            if (vel_pend_q) begin
               sr_d       = {12'd0, vel_hold_q};
               vel_pend_d = 1'b0;
               cur_src_d  = 1'b1;
               cnt_d      = 3'd0;
               state_d    = CONV;
            end else if (note_pend_q && hold_cnt_q == '0) begin
               sr_d        = {12'd0, note_last_q};
               note_pend_d = 1'b0;
               cur_src_d   = 1'b0;
               cnt_d       = 3'd0;
               state_d     = CONV;
            end
         end
         CONV: begin
            if (ten_adj >= 4'd5) ten_adj = ten_adj + 4'd3;
            if (one_adj >= 4'd5) one_adj = one_adj + 4'd3;
            sr_d = {sr_q[17:15], ten_adj, one_adj, sr_q[6:0], 1'b0};
            if (cnt_q == 3'd6) state_d = LOAD;
            else               cnt_d   = cnt_q + 3'd1;
         end
         LOAD: begin
            hun_d   = sr_q[18:15];
            ten_d   = sr_q[14:11];
            one_d   = sr_q[10:7];
            blank_d = {sr_q[18:15] == 4'd0,
                       sr_q[18:15] == 4'd0 && sr_q[14:11] == 4'd0,
                       1'b0};
            src_d   = cur_src_q;
            if (cur_src_q) hold_cnt_d = HOLD_LOAD;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Hold expiry re-queues the last note so the display reverts to it.
      if (hold_cnt_q == HOLD_ONE && hold_cnt_d == '0 && src_q) note_pend_d = 1'b1;

      // Strobes come last so a fresh value survives a same-cycle launch.
      if (note_valid) begin
         note_pend_d = 1'b1;
         note_last_d = note_val;
      end
      if (vel_valid) begin
         vel_pend_d = 1'b1;
         vel_hold_d = vel_val;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments only.
      if (reset) begin
         state_q     <= IDLE;
         note_pend_q <= 1'b0;
         vel_pend_q  <= 1'b0;
         note_last_q <= 7'd0;
         vel_hold_q  <= 7'd0;
         cur_src_q   <= 1'b0;
         sr_q        <= 19'd0;
         cnt_q       <= 3'd0;
         hold_cnt_q  <= '0;
         hun_q       <= 4'd0;
         ten_q       <= 4'd0;
         one_q       <= 4'd0;
         blank_q     <= 3'b110;
         src_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         note_pend_q <= note_pend_d;
         vel_pend_q  <= vel_pend_d;
         note_last_q <= note_last_d;
         vel_hold_q  <= vel_hold_d;
         cur_src_q   <= cur_src_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         hun_q       <= hun_d;
         ten_q       <= ten_d;
         one_q       <= one_d;
         blank_q     <= blank_d;
         src_q       <= src_d;
      end
   end

   assign bcd_hun = hun_q;
   assign bcd_ten = ten_q;
   assign bcd_one = one_q;
   assign blank   = blank_q;
   assign src     = src_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a short hold time; expected
// digits, blank flags and cycle positions are hand-computed.
module tb_hex_display_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       note_valid;
   logic [6:0] note_val;
   logic       vel_valid;
   logic [6:0] vel_val;
   logic [3:0] bcd_hun, bcd_ten, bcd_one;
   logic [2:0] blank;
   logic       src;
   logic       busy;
   logic [11:0] disp;

   int checks = 0;
   int errors = 0;

   hex_display_ctrl #(.HOLD_CYCLES(20), .HOLD_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .note_valid (note_valid),
      .note_val   (note_val),
      .vel_valid  (vel_valid),
      .vel_val    (vel_val),
      .bcd_hun    (bcd_hun),
      .bcd_ten    (bcd_ten),
      .bcd_one    (bcd_one),
      .blank      (blank),
      .src        (src),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign disp = {bcd_hun, bcd_ten, bcd_one};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; sampling and driving happen 1 ns later.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic nv, input logic [6:0] n, input logic vv, input logic [6:0] v);
      note_valid = nv;
      note_val   = n;
      vel_valid  = vv;
      vel_val    = v;
      ticks(1);
      note_valid = 1'b0;
      vel_valid  = 1'b0;
   endtask

   task automatic check_disp(input string tag, input logic [11:0] d, input logic [2:0] b, input logic s);
      check({tag, "_digits"}, 32'(disp), 32'(d));
      check({tag, "_blank"},  32'(blank), 32'(b));
      check({tag, "_src"},    32'(src), 32'(s));
   endtask

   initial begin
      reset = 1'b1; note_valid = 1'b0; vel_valid = 1'b0; note_val = '0; vel_val = '0;
      ticks(2);
      reset = 1'b0;
      check_disp("reset", 12'h000, 3'b110, 1'b0);
      check("reset_busy", 32'(busy), 32'd0);
      ticks(100);
      check_disp("idle100", 12'h000, 3'b110, 1'b0);
      check("idle100_busy", 32'(busy), 32'd0);

      // 127: busy for exactly 8 cycles, result 9 cycles after the strobe.
      strobe(1'b1, 7'd127, 1'b0, 7'd0);
      check("n127_busy_k", 32'(busy), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         ticks(1);
         check("n127_busy", 32'(busy), 32'd1);
      end
      check("n127_early", 32'(disp), 32'h000);
      ticks(1);
      check_disp("n127", 12'h127, 3'b000, 1'b0);
      check("n127_busy_done", 32'(busy), 32'd0);

      strobe(1'b1, 7'd5, 1'b0, 7'd0);
      ticks(9);
      check_disp("n5", 12'h005, 3'b110, 1'b0);
      strobe(1'b1, 7'd42, 1'b0, 7'd0);
      ticks(9);
      check_disp("n42", 12'h042, 3'b100, 1'b0);

      // Velocity 100 held 20 cycles; note 60 waits for expiry.
      strobe(1'b0, 7'd0, 1'b1, 7'd100);
      ticks(9);
      check_disp("v100", 12'h100, 3'b000, 1'b1);
      ticks(4);
      strobe(1'b1, 7'd60, 1'b0, 7'd0);
      ticks(23);
      check_disp("v100_hold", 12'h100, 3'b000, 1'b1);
      check("v100_hold_busy", 32'(busy), 32'd1);
      ticks(1);
      check_disp("n60_after", 12'h060, 3'b100, 1'b0);

      // Simultaneous strobes: velocity first, note after hold expiry.
      strobe(1'b1, 7'd3, 1'b1, 7'd7);
      ticks(9);
      check_disp("sim_v7", 12'h007, 3'b110, 1'b1);
      ticks(28);
      check_disp("sim_v7_hold", 12'h007, 3'b110, 1'b1);
      ticks(1);
      check_disp("sim_n3", 12'h003, 3'b110, 1'b0);

      // New velocity during a hold reloads the timer.
      strobe(1'b0, 7'd0, 1'b1, 7'd50);
      ticks(9);
      check_disp("v50", 12'h050, 3'b100, 1'b1);
      ticks(4);
      strobe(1'b0, 7'd0, 1'b1, 7'd80);
      ticks(9);
      check_disp("v80", 12'h080, 3'b100, 1'b1);
      ticks(28);
      check_disp("v80_reload", 12'h080, 3'b100, 1'b1);
      ticks(1);
      check_disp("v80_revert", 12'h003, 3'b110, 1'b0);

      // Consecutive notes: first and latest are shown, the middle one never.
      strobe(1'b1, 7'd10, 1'b0, 7'd0);
      strobe(1'b1, 7'd11, 1'b0, 7'd0);
      strobe(1'b1, 7'd12, 1'b0, 7'd0);
      ticks(7);
      check_disp("n10", 12'h010, 3'b100, 1'b0);
      ticks(1);
      check("n10_hold1", 32'(disp), 32'h010);
      ticks(7);
      check("n10_hold8", 32'(disp), 32'h010);
      check("n12_busy", 32'(busy), 32'd1);
      ticks(1);
      check_disp("n12", 12'h012, 3'b100, 1'b0);

      // Reset mid-conversion aborts with no later update.
      strobe(1'b1, 7'd99, 1'b0, 7'd0);
      ticks(3);
      reset = 1'b1;
      ticks(1);
      reset = 1'b0;
      check_disp("abort", 12'h000, 3'b110, 1'b0);
      check("abort_busy", 32'(busy), 32'd0);
      ticks(20);
      check_disp("abort_later", 12'h000, 3'b110, 1'b0);
      check("abort_later_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
